// File: rtl/i4001_bank_if.sv
// MCS-4 bus control lines and the shared-ROM port of an i4001 bank.
// The bank is the slave side; the CPU/ROM environment is the master side.
interface i4001_bank_if;
  logic        clk1_pad;
  logic        clk2_pad;
  logic        sync_pad;
  logic        cmrom_pad;
  logic        clear_pad;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        irq;

  modport master (
    output clk1_pad, clk2_pad, sync_pad, cmrom_pad, clear_pad, rom_data,
    input  rom_addr, irq
  );

  modport slave (
    input  clk1_pad, clk2_pad, sync_pad, cmrom_pad, clear_pad, rom_data,
    output rom_addr, irq
  );
endinterface

// File: rtl/i4001_bank.sv
// Bank of CHIP_COUNT emulated i4001 ROM/IO chips on one MCS-4 bus, sampled in the sysclk domain.
// Optional input-change interrupt: define I4001_BANK_CHANGE_IRQ_EN.
module i4001_bank #(
  parameter logic [3:0]              CHIP_BASE   = 4'd0,
  parameter int                      CHIP_COUNT  = 4,
  parameter logic [4*CHIP_COUNT-1:0] IO_OUTPUT   = '0,
  parameter logic [4*CHIP_COUNT-1:0] IO_INVERT   = '0,
  parameter int                      SYNC_STAGES = 2
) (
  input  logic                    sysclk,
  input  logic                    poc_pad,
  i4001_bank_if.slave             bus,
  inout  wire [3:0]               data_pad,
  inout  wire [4*CHIP_COUNT-1:0]  io_pad
);

  localparam int         IO_W = 4 * CHIP_COUNT;
  localparam int         TOP  = SYNC_STAGES - 1;
  localparam logic [4:0] LO   = {1'b0, CHIP_BASE};

  typedef enum logic [3:0] {UNSYNC, A1, A2, A3, M1, M2, X1, X2, X3} phase_e;

  // ---------------- synchronisers and edge detect ----------------
  logic [SYNC_STAGES-1:0] clk1_sq, clk2_sq, sync_sq;
  logic [IO_W-1:0]        io_sq [SYNC_STAGES];
  logic                   clk1_prev_q, clk2_prev_q;

  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      clk1_sq     <= '0;
      clk2_sq     <= '0;
      sync_sq     <= '0;
      clk1_prev_q <= 1'b0;
      clk2_prev_q <= 1'b0;
      // NOTE: this array is a flop chain, not a RAM, so clearing every entry on reset is cheap and wanted.
      for (int i = 0; i < SYNC_STAGES; i++) io_sq[i] <= '0;
    end else begin
      clk1_sq     <= {clk1_sq[SYNC_STAGES-2:0], bus.clk1_pad};
      clk2_sq     <= {clk2_sq[SYNC_STAGES-2:0], bus.clk2_pad};
      sync_sq     <= {sync_sq[SYNC_STAGES-2:0], bus.sync_pad};
      clk1_prev_q <= clk1_sq[TOP];
      clk2_prev_q <= clk2_sq[TOP];
      io_sq[0]    <= io_pad;
      for (int i = 1; i < SYNC_STAGES; i++) io_sq[i] <= io_sq[i-1];
    end
  end

  logic            clk1_rise, clk2_fall, sync_s;
  logic [IO_W-1:0] io_in_val;
  assign clk1_rise = clk1_sq[TOP] & ~clk1_prev_q;
  assign clk2_fall = ~clk2_sq[TOP] & clk2_prev_q;
  assign sync_s    = sync_sq[TOP];
  assign io_in_val = io_sq[TOP] ^ IO_INVERT;

  // Offset of the bus nibble from CHIP_BASE; values below the base wrap above 16.
  logic [4:0] d_off;
  logic       d_in_range;
  assign d_off      = {1'b0, data_pad} - LO;
  assign d_in_range = d_off < 5'(CHIP_COUNT);

  // ---------------- phase tracker and bus state ----------------
  phase_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic [7:0]      addr_q, addr_d;
  logic [11:0]     rom_addr_q, rom_addr_d;
  logic            src_valid_q, src_valid_d;
  logic [3:0]      src_chip_q, src_chip_d;
  logic            wrr_pend_q, wrr_pend_d;
  logic            rdr_pend_q, rdr_pend_d;
  logic [IO_W-1:0] io_out_q, io_out_d;

  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      state_q     <= UNSYNC;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      rom_addr_q  <= '0;
      src_valid_q <= 1'b0;
      src_chip_q  <= '0;
      wrr_pend_q  <= 1'b0;
      rdr_pend_q  <= 1'b0;
      io_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      rom_addr_q  <= rom_addr_d;
      src_valid_q <= src_valid_d;
      src_chip_q  <= src_chip_d;
      wrr_pend_q  <= wrr_pend_d;
      rdr_pend_q  <= rdr_pend_d;
      io_out_q    <= io_out_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    rom_addr_d  = rom_addr_q;
    src_valid_d = src_valid_q;
    src_chip_d  = src_chip_q;
    wrr_pend_d  = wrr_pend_q;
    rdr_pend_d  = rdr_pend_q;
    io_out_d    = io_out_q;

    if (clk2_fall) begin
      unique case (state_q)
        A1: addr_d[3:0] = data_pad;
        A2: addr_d[7:4] = data_pad;
        A3: if (bus.cmrom_pad && d_in_range) begin
          sel_d      = 1'b1;
          rom_addr_d = {CHIP_BASE + d_off[3:0], addr_q};
        end
        M2: if (bus.cmrom_pad && src_valid_q) begin
          if (data_pad == 4'b0010) wrr_pend_d = 1'b1;
          if (data_pad == 4'b1010) rdr_pend_d = 1'b1;
        end
        X2: begin
          if (bus.cmrom_pad) begin
            src_valid_d = d_in_range;
            if (d_in_range) src_chip_d = d_off[3:0];
          end
          if (wrr_pend_q) begin
            for (int c = 0; c < CHIP_COUNT; c++) begin
              if (src_chip_q == 4'(c))
                io_out_d[4*c +: 4] = (io_out_q[4*c +: 4] & ~IO_OUTPUT[4*c +: 4])
                                   | (data_pad & IO_OUTPUT[4*c +: 4]);
            end
          end
        end
        default: ;
      endcase
    end

    // A sync edge starts (or aborts into) a new cycle; src_valid and io_out survive it.
    if (clk1_rise) begin
      if (sync_s) begin
        state_d    = A1;
        sel_d      = 1'b0;
        wrr_pend_d = 1'b0;
        rdr_pend_d = 1'b0;
      end else begin
        unique case (state_q)
          A1:      state_d = A2;
          A2:      state_d = A3;
          A3:      state_d = M1;
          M1:      state_d = M2;
          M2:      state_d = X1;
          X1:      state_d = X2;
          X2:      state_d = X3;
          X3:      state_d = X3;
          default: state_d = UNSYNC;
        endcase
      end
    end

    if (bus.clear_pad) io_out_d = '0;
  end

  // ---------------- data bus driver ----------------
  logic [3:0] rd_val, drv_val;
  logic       drv_en;

  always_comb begin
    rd_val = 4'h0;
    for (int c = 0; c < CHIP_COUNT; c++) begin
      if (src_chip_q == 4'(c))
        rd_val = (io_out_q[4*c +: 4] & IO_OUTPUT[4*c +: 4])
               | (io_in_val[4*c +: 4] & ~IO_OUTPUT[4*c +: 4]);
    end
  end

  always_comb begin
    drv_en  = 1'b0;
    drv_val = 4'h0;
    unique case (state_q)
      M1:      begin drv_en = sel_q;      drv_val = bus.rom_data[7:4]; end
      M2:      begin drv_en = sel_q;      drv_val = bus.rom_data[3:0]; end
      X2:      begin drv_en = rdr_pend_q; drv_val = rd_val;            end
      default: ;
    endcase
  end

  assign data_pad     = drv_en ? drv_val : 4'bz;
  assign bus.rom_addr = rom_addr_q;

  for (genvar b = 0; b < IO_W; b++) begin : g_io_drv
    if (IO_OUTPUT[b]) begin : g_out
      assign io_pad[b] = io_out_q[b] ^ IO_INVERT[b];
    end
  end

  // ---------------- optional input-change interrupt ----------------
`ifdef I4001_BANK_CHANGE_IRQ_EN
  logic [IO_W-1:0]       io_prev_q, io_edge;
  logic [CHIP_COUNT-1:0] chg_q, chg_d;
  logic                  rdr_clr;

  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      io_prev_q <= '0;
      chg_q     <= '0;
    end else begin
      io_prev_q <= io_sq[TOP];
      chg_q     <= chg_d;
    end
  end

  assign io_edge = (io_sq[TOP] ^ io_prev_q) & ~IO_OUTPUT;
  assign rdr_clr = clk1_rise && (state_q == X2) && rdr_pend_q;

  // A fresh edge in the clearing cycle keeps the flag set.
  always_comb begin
    chg_d = chg_q;
    for (int c = 0; c < CHIP_COUNT; c++)
      chg_d[c] = (chg_q[c] & ~(rdr_clr && (src_chip_q == 4'(c)))) | (|io_edge[4*c +: 4]);
  end

  assign bus.irq = |chg_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_i4001_bank.sv
// Directed bench for i4001_bank: CHIP_BASE=2, CHIP_COUNT=4, chip 3 outputs, pin 0 inverted.
// Pull-ups make an undriven bus read 4'hF.
module tb_i4001_bank;
  logic sysclk = 1'b0;
  logic poc_pad;
  always #5 sysclk = ~sysclk;

  i4001_bank_if bus();
  wire [3:0]  data_pad;
  wire [15:0] io_pad;

  logic        tb_d_en;
  logic [3:0]  tb_d_val;
  logic [15:0] tb_io_en, tb_io_val;

  assign data_pad = tb_d_en ? tb_d_val : 4'bz;
  for (genvar b = 0; b < 4; b++) begin : g_dpu
    pullup (data_pad[b]);
  end
  for (genvar b = 0; b < 16; b++) begin : g_io
    assign io_pad[b] = tb_io_en[b] ? tb_io_val[b] : 1'bz;
    pullup (io_pad[b]);
  end

  i4001_bank #(
    .CHIP_BASE (4'd2),
    .CHIP_COUNT(4),
    .IO_OUTPUT (16'h00F0),
    .IO_INVERT (16'h0001)
  ) dut (
    .sysclk  (sysclk),
    .poc_pad (poc_pad),
    .bus     (bus),
    .data_pad(data_pad),
    .io_pad  (io_pad)
  );

  // Shared ROM, one sysclk latency.
  function automatic logic [7:0] rom_byte(input logic [11:0] a);
    case (a)
      12'h35A: return 8'hC7;
      12'h512: return 8'h47;
      default: return 8'h00;
    endcase
  endfunction
  always @(posedge sysclk) bus.rom_data <= rom_byte(bus.rom_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clk1_pulse(input logic sy);
    bus.sync_pad = sy;
    @(negedge sysclk);
    bus.clk1_pad = 1'b1;
    repeat (4) @(negedge sysclk);
    bus.clk1_pad = 1'b0;
    bus.sync_pad = 1'b0;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic clk2_pulse(output logic [3:0] obs);
    bus.clk2_pad = 1'b1;
    repeat (4) @(negedge sysclk);
    obs = data_pad;
    bus.clk2_pad = 1'b0;
    repeat (5) @(negedge sysclk);
  endtask

  task automatic phase(input logic sy, input logic cm, input logic den, input logic [3:0] dv,
                       output logic [3:0] obs);
    bus.cmrom_pad = cm;
    tb_d_en       = den;
    tb_d_val      = dv;
    clk1_pulse(sy);
    clk2_pulse(obs);
  endtask

  task automatic instr(input logic sy, input logic [3:0] a1, a2, a3, input logic cm3,
                       input logic mdrv, input logic [3:0] m1v, m2v, input logic cm2,
                       input logic xdrv, input logic [3:0] x2v, input logic cmx,
                       output logic [3:0] m1o, m2o, x2o);
    logic [3:0] junk;
    phase(sy,   1'b0, 1'b1, a1,   junk);
    phase(1'b0, 1'b0, 1'b1, a2,   junk);
    phase(1'b0, cm3,  1'b1, a3,   junk);
    phase(1'b0, 1'b0, mdrv, m1v,  m1o);
    phase(1'b0, cm2,  mdrv, m2v,  m2o);
    phase(1'b0, 1'b0, 1'b0, 4'h0, junk);
    phase(1'b0, cmx,  xdrv, x2v,  x2o);
    phase(1'b0, 1'b0, 1'b0, 4'h0, junk);
  endtask

  task automatic fetch(input logic sy, input logic [3:0] a1, a2, a3, input logic cm3,
                       output logic [3:0] m1o, m2o, x2o);
    instr(sy, a1, a2, a3, cm3, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, m1o, m2o, x2o);
  endtask

  task automatic src(input logic [3:0] chip);
    logic [3:0] o1, o2, o3;
    instr(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 4'h1, 1'b0, 1'b1, chip, 1'b1, o1, o2, o3);
  endtask

  task automatic wrr(input logic [3:0] v);
    logic [3:0] o1, o2, o3;
    instr(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hE, 4'h2, 1'b1, 1'b1, v, 1'b0, o1, o2, o3);
  endtask

  task automatic rdr(output logic [3:0] x2o);
    logic [3:0] o1, o2;
    instr(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 4'hE, 4'hA, 1'b1, 1'b0, 4'h0, 1'b0, o1, o2, x2o);
  endtask

  initial begin
    logic [3:0] m1o, m2o, x2o, obs;
    poc_pad       = 1'b1;
    bus.clk1_pad  = 1'b0;
    bus.clk2_pad  = 1'b0;
    bus.sync_pad  = 1'b0;
    bus.cmrom_pad = 1'b0;
    bus.clear_pad = 1'b0;
    tb_d_en       = 1'b0;
    tb_d_val      = 4'h0;
    tb_io_en      = 16'h0F00;
    tb_io_val     = 16'h0500;
    repeat (3) @(negedge sysclk);

    check("reset rom_addr", 16'(bus.rom_addr), 16'h000);
    check("reset data_pad", 16'(data_pad), 16'hF);
    check("reset io_out",   16'(io_pad[7:4]), 16'h0);
    check("reset irq",      16'(bus.irq), 16'h0);

    poc_pad = 1'b0;
    repeat (3) @(negedge sysclk);

    // No sync yet: the bank stays off the bus.
    fetch(1'b0, 4'hA, 4'h5, 4'h3, 1'b1, m1o, m2o, x2o);
    check("unsync m1", 16'(m1o), 16'hF);
    check("unsync m2", 16'(m2o), 16'hF);
    check("unsync rom_addr", 16'(bus.rom_addr), 16'h000);

    fetch(1'b1, 4'hA, 4'h5, 4'h3, 1'b1, m1o, m2o, x2o);
    check("fetch rom_addr", 16'(bus.rom_addr), 16'h35A);
    check("fetch m1", 16'(m1o), 16'hC);
    check("fetch m2", 16'(m2o), 16'h7);
    check("fetch x2", 16'(x2o), 16'hF);

    fetch(1'b1, 4'h2, 4'h1, 4'h7, 1'b1, m1o, m2o, x2o);
    check("above m1", 16'(m1o), 16'hF);
    check("above m2", 16'(m2o), 16'hF);
    check("above rom_addr", 16'(bus.rom_addr), 16'h35A);

    fetch(1'b1, 4'h2, 4'h1, 4'h1, 1'b1, m1o, m2o, x2o);
    check("below m1", 16'(m1o), 16'hF);
    check("below rom_addr", 16'(bus.rom_addr), 16'h35A);

    fetch(1'b1, 4'h2, 4'h1, 4'h3, 1'b0, m1o, m2o, x2o);
    check("nocm m1", 16'(m1o), 16'hF);
    check("nocm rom_addr", 16'(bus.rom_addr), 16'h35A);

    fetch(1'b1, 4'h2, 4'h1, 4'h5, 1'b1, m1o, m2o, x2o);
    check("last chip rom_addr", 16'(bus.rom_addr), 16'h512);
    check("last chip m1", 16'(m1o), 16'h4);
    check("last chip m2", 16'(m2o), 16'h7);

    src(4'h3); wrr(4'h9);
    check("wrr chip1 pins", 16'(io_pad[7:4]), 16'h9);
    src(4'h2); wrr(4'h9);
    check("wrr input chip hiz", 16'(io_pad[3:0]), 16'hF);
    check("wrr chip1 kept", 16'(io_pad[7:4]), 16'h9);

    src(4'h7); wrr(4'h3);
    check("bad src no write", 16'(io_pad[7:4]), 16'h9);

    bus.clear_pad = 1'b1;
    @(negedge sysclk);
    bus.clear_pad = 1'b0;
    check("clear", 16'(io_pad[7:4]), 16'h0);

    src(4'h3); wrr(4'h6); rdr(x2o);
    check("rdr output readback", 16'(x2o), 16'h6);
    check("wrr after clear", 16'(io_pad[7:4]), 16'h6);

    tb_io_en[3:0]  = 4'hF;
    tb_io_val[3:0] = 4'b0110;
    repeat (4) @(negedge sysclk);
    src(4'h2); rdr(x2o);
    check("rdr inverted input", 16'(x2o), 16'h7);
    src(4'h4); rdr(x2o);
    check("rdr chip2", 16'(x2o), 16'h5);
    src(4'h5); rdr(x2o);
    check("rdr chip3 pulled", 16'(x2o), 16'hF);

`ifdef I4001_BANK_CHANGE_IRQ_EN
    check("irq cleared by rdr", 16'(bus.irq), 16'h0);
    tb_io_val[0] = 1'b1;
    repeat (2) @(negedge sysclk);
    check("irq before sync delay", 16'(bus.irq), 16'h0);
    @(negedge sysclk);
    check("irq set", 16'(bus.irq), 16'h1);
    src(4'h2); rdr(x2o);
    check("rdr after toggle", 16'(x2o), 16'h6);
    check("irq cleared", 16'(bus.irq), 16'h0);
`else
    tb_io_val[0] = 1'b1;
    repeat (4) @(negedge sysclk);
    check("irq tied low", 16'(bus.irq), 16'h0);
`endif

    // Sync in what would be M2 aborts the fetch and releases the bus.
    src(4'h4);
    phase(1'b1, 1'b0, 1'b1, 4'hA, obs);
    phase(1'b0, 1'b0, 1'b1, 4'h5, obs);
    phase(1'b0, 1'b1, 1'b1, 4'h3, obs);
    phase(1'b0, 1'b0, 1'b0, 4'h0, m1o);
    check("abort pre m1", 16'(m1o), 16'hC);
    phase(1'b1, 1'b0, 1'b0, 4'h0, obs);
    check("abort released", 16'(obs), 16'hF);
    rdr(x2o);
    check("src kept after abort", 16'(x2o), 16'h5);

    // Power-on clear in the middle of an M1 drive.
    phase(1'b1, 1'b0, 1'b1, 4'hA, obs);
    phase(1'b0, 1'b0, 1'b1, 4'h5, obs);
    phase(1'b0, 1'b1, 1'b1, 4'h3, obs);
    tb_d_en = 1'b0;
    bus.cmrom_pad = 1'b0;
    clk1_pulse(1'b0);
    bus.clk2_pad = 1'b1;
    repeat (2) @(negedge sysclk);
    check("m1 before poc", 16'(data_pad), 16'hC);
    check("io before poc", 16'(io_pad[7:4]), 16'h6);
    poc_pad = 1'b1;
    #1;
    check("poc data hiz", 16'(data_pad), 16'hF);
    check("poc io_out", 16'(io_pad[7:4]), 16'h0);
    check("poc rom_addr", 16'(bus.rom_addr), 16'h000);
    @(negedge sysclk);
    bus.clk2_pad = 1'b0;
    poc_pad = 1'b0;
    repeat (5) @(negedge sysclk);

    fetch(1'b0, 4'hA, 4'h5, 4'h3, 1'b1, m1o, m2o, x2o);
    check("post poc unsync m1", 16'(m1o), 16'hF);
    fetch(1'b1, 4'hA, 4'h5, 4'h3, 1'b1, m1o, m2o, x2o);
    check("post poc m1", 16'(m1o), 16'hC);
    check("post poc m2", 16'(m2o), 16'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
